lemming_fsm: RTL and testbench



---
 rtl/lemming_fsm.sv | 108 ++++++++++
 tb/tb_lemming_fsm.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/lemming_fsm.sv
// Lemmings-style walker: walks, reverses on bumps, digs, falls and splatters
// after an over-long fall. Moore machine; outputs depend only on state.
module lemming_fsm #(
   parameter int FALL_LIMIT = 20,
   parameter int CNT_W      = 5
) (
   input  logic clk,
   input  logic areset,
   input  logic bump_left,
   input  logic bump_right,
   input  logic ground,
   input  logic dig,
   output logic walk_left,
   output logic walk_right,
   output logic aaah,
   output logic digging
);

   typedef enum logic [2:0] {
      WALK_L,
      WALK_R,
      FALL_L,
      FALL_R,
      DIG_L,
      DIG_R,
      SPLAT
   } state_e;

   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(FALL_LIMIT);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FALL_LIMIT + 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             falling;
   logic             too_long;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge, independent of block order.
   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         state_q <= WALK_L;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign falling = (state_q == FALL_L) || (state_q == FALL_R);

   // cnt_q holds completed fall cycles before the current one, so landing
   // with cnt_q >= FALL_LIMIT means aaah was high for more than FALL_LIMIT cycles.
   assign too_long = (cnt_q >= CNT_LIMIT);

   always_comb begin
      cnt_d = '0;
      if (falling) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      end
   end

   // NOTE: every combinational output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         WALK_L: begin
            if (!ground)        state_d = FALL_L;
            else if (dig)       state_d = DIG_L;
            else if (bump_left) state_d = WALK_R;
         end
         WALK_R: begin
            if (!ground)         state_d = FALL_R;
            else if (dig)        state_d = DIG_R;
            else if (bump_right) state_d = WALK_L;
         end
         FALL_L: begin
            if (ground) state_d = too_long ? SPLAT : WALK_L;
         end
         FALL_R: begin
            if (ground) state_d = too_long ? SPLAT : WALK_R;
         end
         DIG_L: begin
            if (!ground) state_d = FALL_L;
         end
         DIG_R: begin
            if (!ground) state_d = FALL_R;
         end
         SPLAT:   state_d = SPLAT;
         default: state_d = WALK_L;
      endcase
   end

   always_comb begin
      walk_left  = 1'b0;
      walk_right = 1'b0;
      aaah       = 1'b0;
      digging    = 1'b0;
      unique case (state_q)
         WALK_L:        walk_left  = 1'b1;
         WALK_R:        walk_right = 1'b1;
         FALL_L, FALL_R: aaah      = 1'b1;
         DIG_L, DIG_R:  digging    = 1'b1;
         default:       ;
      endcase
   end

endmodule

// File: tb/tb_lemming_fsm.sv
// Scoreboard bench for lemming_fsm: the driver queues expected outputs
// {walk_left, walk_right, aaah, digging}; a monitor pops and compares each cycle.
module tb_lemming_fsm;

   localparam logic [3:0] WL = 4'b1000;
   localparam logic [3:0] WR = 4'b0100;
   localparam logic [3:0] AA = 4'b0010;
   localparam logic [3:0] DG = 4'b0001;
   localparam logic [3:0] SP = 4'b0000;

   typedef struct {
      logic [3:0] val;
      string      name;
   } exp_t;

   logic clk = 1'b0;
   logic areset;
   logic bump_left, bump_right, ground, dig;
   logic walk_left, walk_right, aaah, digging;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   lemming_fsm dut (
      .clk        (clk),
      .areset     (areset),
      .bump_left  (bump_left),
      .bump_right (bump_right),
      .ground     (ground),
      .dig        (dig),
      .walk_left  (walk_left),
      .walk_right (walk_right),
      .aaah       (aaah),
      .digging    (digging)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] outs();
      return {walk_left, walk_right, aaah, digging};
   endfunction

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b (wl,wr,aaah,dig)", name, act, exp);
   endtask

   // Inputs change on the falling edge; the expectation is for the next rising edge.
   task automatic step(input logic bl, input logic br, input logic g, input logic d,
                       input logic [3:0] e, input string n);
      exp_t x;
      @(negedge clk);
      bump_left  = bl;
      bump_right = br;
      ground     = g;
      dig        = d;
      x.val  = e;
      x.name = n;
      exp_q.push_back(x);
   endtask

   task automatic fall(input int cycles, input string n);
      for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0, 1'b0, AA, n);
   endtask

   // Monitor: compares one queued expectation shortly after each rising edge.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check(x.name, outs(), x.val);
         end
      end
   end

   initial begin
      exp_t x;
      int   budget;
      areset     = 1'b0;
      bump_left  = 1'b0;
      bump_right = 1'b0;
      ground     = 1'b1;
      dig        = 1'b0;
      #1;
      check("reset_state", outs(), WL);
      #1;
      areset = 1'b1;

      // Bumps while walking
      step(1, 0, 1, 0, WR, "bump_left_turns_right");
      step(0, 1, 1, 0, WL, "bump_right_turns_left");
      step(1, 1, 1, 0, WR, "both_bumps_toggle_1");
      step(1, 1, 1, 0, WL, "both_bumps_toggle_2");
      step(0, 1, 1, 0, WL, "rear_bump_ignored_left");
      step(1, 0, 1, 0, WR, "turn_right");
      step(1, 0, 1, 0, WR, "rear_bump_ignored_right");

      // Dig beats bump, fall from dig keeps direction, short fall survives
      step(0, 1, 1, 1, DG, "dig_beats_bump");
      step(1, 1, 1, 1, DG, "dig_ignores_inputs");
      step(0, 0, 0, 0, AA, "dig_to_fall_1");
      step(0, 0, 0, 0, AA, "dig_to_fall_2");
      step(0, 0, 0, 0, AA, "dig_to_fall_3");
      step(0, 0, 1, 0, WR, "land_right_after_3");
      step(0, 1, 1, 0, WL, "turn_left");

      // 20-cycle fall survives, 21-cycle fall splats
      fall(20, "fall20");
      step(0, 0, 1, 0, WL, "survive_fall20");
      fall(21, "fall21");
      step(0, 0, 1, 0, SP, "splat_fall21");
      for (int i = 0; i < 12; i++)
         step(i[0], i[1], i[2], ~i[0], SP, "splat_absorbing");

      // Async reset out of SPLAT, release straight into a dig
      @(negedge clk);
      #2;
      areset = 1'b0;
      ground = 1'b1;
      dig    = 1'b1;
      bump_left  = 1'b0;
      bump_right = 1'b0;
      #1;
      check("async_reset_from_splat", outs(), WL);
      x.val  = DG;
      x.name = "dig_after_release";
      exp_q.push_back(x);
      #1;
      areset = 1'b1;

      // Dig left, fall with toggling inputs, land back facing left
      step(0, 0, 0, 0, AA, "dig_left_falls");
      step(1, 0, 0, 0, AA, "fall_ignores_bump_left");
      step(0, 1, 0, 1, AA, "fall_ignores_bump_right_dig");
      step(1, 1, 0, 1, AA, "fall_ignores_all");
      step(0, 0, 1, 0, WL, "land_restores_left");

      // Right-facing fall from walking
      step(1, 0, 1, 0, WR, "turn_right_again");
      step(1, 0, 0, 1, AA, "fall_wins_over_dig_bump");
      step(0, 1, 0, 0, AA, "fall_right_2");
      step(0, 0, 1, 0, WR, "land_restores_right");
      step(0, 1, 1, 0, WL, "turn_left_again");

      // Reset mid-fall at fall_cnt=15 must clear the counter
      fall(16, "fall_before_reset");
      @(negedge clk);
      #2;
      areset = 1'b0;
      ground = 1'b1;
      dig    = 1'b0;
      #1;
      check("async_reset_mid_fall", outs(), WL);
      #1;
      areset = 1'b1;
      fall(20, "fall20_after_reset");
      step(0, 0, 1, 0, WL, "survive_after_reset");
      step(0, 0, 1, 0, WL, "hold_left");

      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      #2;
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain_timeout: %0d expectations left, expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
